// File: rtl/syncfilter_pkg.sv
// Shared helpers for the syncfilter input synchronizer/filter.
package syncfilter_pkg;

   // Width of a counter that can hold values up to FILTER.
   function automatic int cnt_width(input int filter);
      return (filter < 1) ? 1 : $clog2(filter + 1);
   endfunction

endpackage

// File: rtl/syncfiltercell.sv
// One channel: flop synchronizer chain, stability counter, filtered level and edge pulses.
module syncfiltercell
   import syncfilter_pkg::*;
#(
   parameter int   STAGES   = 2,
   parameter int   FILTER   = 4,
   parameter logic RESETVAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   localparam int            CW       = cnt_width(FILTER);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

   logic [STAGES-1:0] sync_reg, sync_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic              q_reg, q_next;
   logic              rise_reg, rise_next;
   logic              fall_reg, fall_next;
   logic              s;

   assign s = sync_reg[STAGES-1];

   always_comb begin
      sync_next = {sync_reg[STAGES-2:0], d};
      cnt_next  = '0;
      q_next    = q_reg;
      rise_next = 1'b0;
      fall_next = 1'b0;
      // Any cycle where s agrees with q discards the partial count.
      if (s != q_reg) begin
         if (cnt_reg == CNT_LAST) begin
            q_next    = s;
            rise_next = s;
            fall_next = ~s;
         end else begin
            cnt_next = cnt_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= {STAGES{RESETVAL}};
         cnt_reg  <= '0;
         q_reg    <= RESETVAL;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         sync_reg <= sync_next;
         cnt_reg  <= cnt_next;
         q_reg    <= q_next;
         rise_reg <= rise_next;
         fall_reg <= fall_next;
      end
   end

   assign q    = q_reg;
   assign rise = rise_reg;
   assign fall = fall_reg;

endmodule

// File: rtl/syncfilter.sv
// Multi-bit asynchronous input synchronizer with per-bit glitch filter and edge detect.
module syncfilter
   import syncfilter_pkg::*;
#(
   parameter int               WIDTH    = 1,
   parameter int               STAGES   = 2,
   parameter int               FILTER   = 4,
   parameter logic [WIDTH-1:0] RESETVAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   if (STAGES < 2 || FILTER < 1) begin : g_bad_params
      $error("syncfilter: STAGES must be >= 2 and FILTER must be >= 1");
   end

   // Channels are fully independent; no cross-bit coherency.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      syncfiltercell #(
         .STAGES   (STAGES),
         .FILTER   (FILTER),
         .RESETVAL (RESETVAL[gi])
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .d     (d[gi]),
         .q     (q[gi]),
         .rise  (rise[gi]),
         .fall  (fall[gi])
      );
   end

endmodule
